mul2x2_mac: RTL and testbench

Sequential multiply-accumulate stage directly downstream of the 2x2-bit multiplier. It accepts a stream of operand pairs {a,b} x {c,d} over a valid/ready handshake and forms each 4-bit product {f3,f2,f1,f0} internally. It sums N_TERMS consecutive products into one result and presents that result over a second valid/ready handshake, turning the combinational multiplier into a small dot-product unit.

---
 rtl/mul_pkg.sv | 36 +++
 rtl/mul2x2_comb.sv | 20 ++
 rtl/mul2x2_mac.sv | 110 +++++++++++
 tb/tb_mul2x2_mac.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the 2x2 multiply-accumulate stage.
// Holds the product width, the FSM state enum and the saturating add.
package mul_pkg;

  localparam int PRODUCT_W = 4;
  localparam int SAT_W     = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_t;

  // Snapshot of the control path, kept in one place for probing.
  typedef struct packed {
    mac_state_t state;
    logic       in_xfer;
    logic       out_xfer;
    logic       last_term;
  } mac_dbg_t;

  // Adds a product to an accumulator that is `width` bits wide (width <= SAT_W).
  // Bit SAT_W of the return value flags that the result was clamped to 2^width-1.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                             input logic [PRODUCT_W-1:0] prod,
                                             input int width);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] max;
    sum = {1'b0, acc} + {{(SAT_W - PRODUCT_W + 1){1'b0}}, prod};
    max = ((SAT_W + 1)'(1) << width) - (SAT_W + 1)'(1);
    if (sum > max) begin
      return {1'b1, max[SAT_W-1:0]};
    end
    return {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/mul2x2_comb.sv
// Combinational 2x2-bit unsigned multiplier: {a,b} * {c,d} = {f3,f2,f1,f0}.
// Same port shape as the upstream multiplier so it can be swapped in directly.
module mul2x2_comb (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f3,
  output logic f2,
  output logic f1,
  output logic f0
);

  // f2 and f3 are mutually exclusive: only 3*3 reaches bit 3, and 9 has bit 2 clear.
  assign f0 = b & d;
  assign f1 = (a & d) ^ (b & c);
  assign f2 = (a & c) & ~(b & d);
  assign f3 = a & b & c & d;

endmodule

// File: rtl/mul2x2_mac.sv
// Multiply-accumulate stage: sums N_TERMS 2x2 products with saturation and
// hands the result downstream over a valid/ready port.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never waits on ready, ready never depends on valid, and a
// presented payload stays stable until its transfer.
module mul2x2_mac
  import mul_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS);

  mac_state_t               state_q;
  mac_state_t               state_d;
  mac_dbg_t                 dbg;
  logic [ACC_W-1:0]         acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_q;
  logic [ACC_W-1:0]         out_sum_q;
  logic                     out_ovf_q;
  logic [PRODUCT_W-1:0]     product;
  logic [SAT_W:0]           sat_res;
  logic [ACC_W-1:0]         acc_sum;
  logic                     carry;
  logic                     unused_sat;

  mul2x2_comb u_mul (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .f3 (product[3]),
    .f2 (product[2]),
    .f1 (product[1]),
    .f0 (product[0])
  );

  assign sat_res    = sat_add(SAT_W'(acc_q), product, ACC_W);
  assign acc_sum    = sat_res[ACC_W-1:0];
  assign carry      = sat_res[SAT_W];
  assign unused_sat = ^sat_res;

  // Ready/valid come straight from the state register, never from the peer's strobe.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  assign dbg.state     = state_q;
  assign dbg.in_xfer   = in_valid & in_ready;
  assign dbg.out_xfer  = out_valid & out_ready;
  assign dbg.last_term = (cnt_q == CNT_W'(N_TERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (dbg.state)
      ACCUM: if (dbg.in_xfer && dbg.last_term) state_d = HOLD;
      HOLD:  if (dbg.out_xfer) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else if (dbg.in_xfer) begin
      if (dbg.last_term) begin
        // Final term: publish the result and start the next sum from zero.
        out_sum_q <= acc_sum;
        out_ovf_q <= ovf_q | carry;
        acc_q     <= '0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
      end else begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + CNT_W'(1);
        ovf_q <= ovf_q | carry;
      end
    end
  end

endmodule

// File: tb/tb_mul2x2_mac.sv
// Bench for mul2x2_mac: two instances (8-bit and 5-bit accumulators) share one
// operand stream; results are predicted from the sum of products and clamped.
module tb_mul2x2_mac;

  localparam int N_TERMS = 4;
  localparam int W8      = 8;
  localparam int W5      = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          a, b, c, d;
  logic          out_ready;
  logic          in_ready8, in_ready5;
  logic          out_valid8, out_valid5;
  logic [W8-1:0] out_sum8;
  logic [W5-1:0] out_sum5;
  logic          out_ovf8, out_ovf5;

  logic [W8:0]   exp8_q[$];
  logic [W5:0]   exp5_q[$];
  logic [3:0]    dir_t[4];

  int n_vec = 0;
  int n_err = 0;
  int m_sum = 0;
  int m_cnt = 0;
  bit rnd_ready = 1'b0;
  bit done = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mul2x2_mac #(.N_TERMS(N_TERMS), .ACC_W(W8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_sum   (out_sum8),
    .out_ovf   (out_ovf8)
  );

  mul2x2_mac #(.N_TERMS(N_TERMS), .ACC_W(W5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready5),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid5),
    .out_ready (out_ready),
    .out_sum   (out_sum5),
    .out_ovf   (out_ovf5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int s, input int w);
    int max;
    max = (1 << w) - 1;
    return (s > max) ? max : s;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [3:0] t);
    logic [1:0] x;
    logic [1:0] y;
    x = t[3:2];
    y = t[1:0];
    m_sum += int'(x) * int'(y);
    m_cnt++;
    if (m_cnt == N_TERMS) begin
      exp8_q.push_back({(m_sum > (1 << W8) - 1), W8'(clamp(m_sum, W8))});
      exp5_q.push_back({(m_sum > (1 << W5) - 1), W5'(clamp(m_sum, W5))});
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] t);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    {a, b, c, d} = t;
    while (!in_ready8) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      waited++;
      if (waited > 200) begin
        check("in_ready timeout", 32'(in_ready8), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    model_accept(t);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor();
    logic [W8:0] e8;
    logic [W5:0] e5;
    while (!done) begin
      @(negedge clk);
      if (rst_n && out_ready && out_valid8) begin
        if (exp8_q.size() == 0) check("unexpected result acc8", 32'(out_valid8), 32'd0);
        else begin
          e8 = exp8_q.pop_front();
          check("result acc8 {ovf,sum}", 32'({out_ovf8, out_sum8}), 32'(e8));
        end
      end
      if (rst_n && out_ready && out_valid5) begin
        if (exp5_q.size() == 0) check("unexpected result acc5", 32'(out_valid5), 32'd0);
        else begin
          e5 = exp5_q.pop_front();
          check("result acc5 {ovf,sum}", 32'({out_ovf5, out_sum5}), 32'(e5));
        end
      end
    end
  endtask

  task automatic stimulus();
    dir_t[0] = 4'b0101;
    dir_t[1] = 4'b1010;
    dir_t[2] = 4'b1111;
    dir_t[3] = 4'b0111;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid8), 32'd0);
    check("reset out_sum", 32'(out_sum8), 32'd0);
    check("reset out_ovf", 32'(out_ovf8), 32'd0);
    check("reset in_ready", 32'(in_ready8), 32'd1);
    rst_n = 1'b1;

    // directed sum, streaming
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(dir_t[i]);
    check("directed out_valid", 32'(out_valid8), 32'd1);
    check("directed out_sum", 32'(out_sum8), 32'd17);
    check("directed out_ovf", 32'(out_ovf8), 32'd0);
    check("directed in_ready in hold", 32'(in_ready8), 32'd0);
    idle(1);
    check("directed single-cycle valid", 32'(out_valid8), 32'd0);

    // exhaustive sweep 0..15
    for (int t = 0; t < 16; t++) send(4'(t));
    idle(1);

    // backpressure: terms offered in HOLD must not be consumed
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(dir_t[i]);
    in_valid = 1'b1;
    {a, b, c, d} = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check("bp in_ready", 32'(in_ready8), 32'd0);
      check("bp out_valid", 32'(out_valid8), 32'd1);
      check("bp out_sum held", 32'(out_sum8), 32'd17);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(4'b1010);
    check("bp next result", 32'(out_sum8), 32'd16);
    idle(1);

    // input gaps
    for (int i = 0; i < 4; i++) begin
      send(dir_t[i]);
      if (i < 3) begin
        idle(3);
        check("gap no early valid", 32'(out_valid8), 32'd0);
      end
    end
    check("gap out_valid", 32'(out_valid8), 32'd1);
    check("gap out_sum", 32'(out_sum8), 32'd17);
    idle(1);

    // saturation on the 5-bit instance
    for (int i = 0; i < 4; i++) send(4'b1111);
    check("sat acc5 sum", 32'(out_sum5), 32'd31);
    check("sat acc5 ovf", 32'(out_ovf5), 32'd1);
    check("sat acc8 sum", 32'(out_sum8), 32'd36);
    idle(1);
    for (int i = 0; i < 4; i++) send(4'b0101);
    check("post-sat acc5 sum", 32'(out_sum5), 32'd4);
    check("post-sat acc5 ovf", 32'(out_ovf5), 32'd0);
    idle(1);

    // asynchronous reset after two accepted terms
    send(4'b1111);
    send(4'b1111);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid8), 32'd0);
    check("async rst out_sum acc8", 32'(out_sum8), 32'd0);
    check("async rst out_sum acc5", 32'(out_sum5), 32'd0);
    m_sum = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(4'b1010);
    check("post-reset out_sum", 32'(out_sum8), 32'd16);
    idle(1);

    // random operands, gaps and downstream stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send(4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("drained acc8 queue", 32'(exp8_q.size()), 32'd0);
    check("drained acc5 queue", 32'(exp5_q.size()), 32'd0);
    done = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    {a, b, c, d} = 4'b0000;
    out_ready = 1'b0;
    fork
      monitor();
      stimulus();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
